song_reader: RTL and testbench
==============================

// Module: song_reader
// PURPOSE
//  Sequencer that walks song_rom and drives the note players. Issues addr and
//  decodes the registered 16-bit dout. Load words fill chord voice slots. A play
//  word releases the chord and holds it for a number of beats. Sits between
//  song_rom and the per-voice note players, paced by the tempo beat strobe.
// PARAMETERS
//  ADDR_W  6  ROM address width (matches song_rom addr)
//  SONG_W  2  song-select width; each song region = 2**(ADDR_W-SONG_W) = 16 words
//  NOTE_W  6  note code width; code 0 = rest
//  DUR_W   6  play-word duration width, in beats
//  VOICES  3  chord voice slots
// PORTS
//  clk        in   1                clock
//  reset      in   1                async, active-high
//  play       in   1                1 = run/resume, 0 = pause (from IDLE/DONE: stop)
//  song_sel   in   SONG_W           song region; sampled only when leaving IDLE
//  beat       in   1                1-cycle tempo strobe
//  addr       out  ADDR_W           song_rom address (registered)
//  dout       in   16               song_rom data, valid 1 cycle after addr changes
//  notes      out  VOICES*NOTE_W    chord being played; slot 0 in LSBs
//  new_chord  out  1                1-cycle pulse when notes update
//  playing    out  1                1 while in WAIT and play=1
//  song_done  out  1                1-cycle pulse on end-of-song
// BEHAVIOUR
//  Reset: async clear. addr=0, notes=0, new_chord=0, playing=0, song_done=0.
//   Slot index=0. Beat count=0. State=IDLE. Reset mid-song aborts immediately.
//  Word decode (dout):
//   dout[15]=0 is a load word. Note = dout[14:9]; dout[8:0] reserved, ignored.
//    The note goes to pending slot[idx], then idx++.
//    With idx==VOICES, the load is dropped (no wrap, no overwrite).
//   dout[15]=1 is a play word. Duration = dout[14:9] beats; dout[8:0] ignored.
//    Duration 0 is the end-of-song marker.
//  FSM:
//   IDLE: on play=1, latch base={song_sel,0}, set addr=base, clear pending slots,
//    then go to FETCH.
//   FETCH: one cycle, covering ROM latency. Then go to DECODE.
//   DECODE, load word: store the note, addr=next, then go to FETCH.
//   DECODE, play word with dur>0: notes<=pending and pulse new_chord.
//    Clear pending slots and idx. Set cnt=dur. Go to WAIT.
//   DECODE, play word with dur=0: pulse song_done and go to END handling.
//   WAIT: each beat decrements cnt. If cnt==1 and beat=1, set addr=next and go
//    to FETCH. Notes hold until the next chord.
//   DONE: notes=0. Stay until play=0, then go to IDLE.
//  Address: next = base | ((addr+1) & region mask). Addr never leaves the region.
//   Wrapping from the region's last word to base acts as end-of-song:
//   song_done pulses and END handling applies.
//  Pause: play=0 outside IDLE/DONE freezes state, addr and cnt.
//   While paused, notes output reads 0 and beats are ignored.
//   When play returns to 1, the held notes reappear and counting resumes.
//  Beats outside WAIT are ignored and not banked.
//   A beat on the cycle WAIT is entered is not counted.
//  song_sel changes while running are ignored until the next IDLE exit.
// CONFIGURATION
//  SONG_READER_LOOP_EN defined: END handling sets addr=base, clears notes, and
//   goes to FETCH. The song loops forever and song_done pulses once per pass.
//  Not defined: END handling clears notes and goes to DONE.
// TESTING
//  1 Chord: ROM = {load 63, load 56, load 59, play 12}, play=1.
//    Expect new_chord once with notes={59,56,63}. Expect exactly 12 beats
//    before addr=4 is fetched.
//  2 Overflow: four loads 10,20,30,40 then play 2. Expect notes={30,20,10};
//    40 is dropped.
//  3 Partial chord then end: load 7, play 1, then play 0.
//    Expect notes={0,0,7} for one beat, then a song_done pulse.
//    Loop off: DONE with notes=0 until play=0.
//  4 Wrap: song_sel=1 and a region with no end marker. After addr=31, expect
//    song_done and then addr=16 (loop on) or DONE (loop off). addr never reaches 32.
//  5 Pause: drop play mid-WAIT with cnt=5 and apply 3 beats. Expect notes=0 and
//    cnt=5. Restore play: the same chord returns and 5 more beats are needed.
//  6 Async reset asserted mid-WAIT: all outputs 0 the same cycle. After
//    release and play=1, the next fetch is at the song base.

Source files
------------

// File: rtl/song_reader_if.sv
// Bus between song_reader, song_rom and the note players.
// Master side is the sequencer; slave side is the ROM/player environment.
interface song_reader_if #(
  parameter int ADDR_W = 6,
  parameter int SONG_W = 2,
  parameter int NOTE_W = 6,
  parameter int VOICES = 3
);
  logic                     play;
  logic [SONG_W-1:0]        song_sel;
  logic                     beat;
  logic [ADDR_W-1:0]        addr;
  logic [15:0]              dout;
  logic [VOICES*NOTE_W-1:0] notes;
  logic                     new_chord;
  logic                     playing;
  logic                     song_done;

  modport master (
    input  play, song_sel, beat, dout,
    output addr, notes, new_chord, playing, song_done
  );

  modport slave (
    output play, song_sel, beat, dout,
    input  addr, notes, new_chord, playing, song_done
  );
endinterface

// File: rtl/song_reader.sv
// Song sequencer: walks a song_rom region, builds chords from load words and holds them for play-word beats.
// Optional SONG_READER_LOOP_EN: end-of-song restarts at the region base instead of stopping in DONE.
module song_reader #(
  parameter int ADDR_W = 6,
  parameter int SONG_W = 2,
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6,
  parameter int VOICES = 3
) (
  input logic           clk,
  input logic           reset,
  song_reader_if.master bus
);
  localparam int REG_W = ADDR_W - SONG_W;
  localparam int IDX_W = $clog2(VOICES + 1);
  localparam int CHD_W = VOICES * NOTE_W;
  localparam logic [ADDR_W-1:0] MASK = ADDR_W'((1 << REG_W) - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t             state_r, state_s;
  logic [ADDR_W-1:0]  addr_r, addr_s;
  logic [ADDR_W-1:0]  base_r, base_s;
  logic [CHD_W-1:0]   pend_r, pend_s;
  logic [IDX_W-1:0]   idx_r, idx_s;
  logic [DUR_W-1:0]   cnt_r, cnt_s;
  logic [CHD_W-1:0]   chord_r, chord_s;
  logic [CHD_W-1:0]   notes_r, notes_s;
  logic               new_chord_r, new_chord_s;
  logic               song_done_r, song_done_s;
  logic               playing_r, playing_s;
  logic               end_s;
  logic [ADDR_W-1:0]  next_addr_s;
  logic               wrap_s;
  logic [NOTE_W-1:0]  note_s;
  logic [DUR_W-1:0]   dur_s;
  logic               unused_s;

  assign note_s      = bus.dout[14 -: NOTE_W];
  assign dur_s       = bus.dout[14 -: DUR_W];
  assign unused_s    = ^bus.dout[8:0];
  // Address stays inside the song region; the last word is where wrap happens.
  assign next_addr_s = base_r | ((addr_r + ADDR_W'(1)) & MASK);
  assign wrap_s      = ((addr_r & MASK) == MASK);

  // Next-state and datapath decode; pause (play=0) simply leaves everything at its default hold.
  always_comb begin
    state_s     = state_r;
    addr_s      = addr_r;
    base_s      = base_r;
    pend_s      = pend_r;
    idx_s       = idx_r;
    cnt_s       = cnt_r;
    chord_s     = chord_r;
    new_chord_s = 1'b0;
    song_done_s = 1'b0;
    end_s       = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (bus.play) begin
          base_s  = {bus.song_sel, {REG_W{1'b0}}};
          addr_s  = {bus.song_sel, {REG_W{1'b0}}};
          pend_s  = '0;
          idx_s   = '0;
          state_s = ST_FETCH;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (bus.play) begin
          state_s = ST_DECODE;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (!bus.play) begin
          state_s = ST_DECODE;
        end else if (!bus.dout[15]) begin
          // Loads beyond the last voice slot are dropped rather than wrapping.
          for (int v = 0; v < VOICES; v++) begin
            if (idx_r == IDX_W'(v)) begin
              pend_s[v*NOTE_W +: NOTE_W] = note_s;
            end else begin
              pend_s[v*NOTE_W +: NOTE_W] = pend_r[v*NOTE_W +: NOTE_W];
            end
          end
          if (idx_r < IDX_W'(VOICES)) begin
            idx_s = idx_r + IDX_W'(1);
          end else begin
            idx_s = idx_r;
          end
          if (wrap_s) begin
            end_s = 1'b1;
          end else begin
            addr_s  = next_addr_s;
            state_s = ST_FETCH;
          end
        end else if (dur_s != DUR_W'(0)) begin
          chord_s     = pend_r;
          new_chord_s = 1'b1;
          pend_s      = '0;
          idx_s       = '0;
          cnt_s       = dur_s;
          state_s     = ST_WAIT;
        end else begin
          end_s = 1'b1;
        end
      end
      ST_WAIT: begin
        if (bus.play && bus.beat) begin
          if (cnt_r == DUR_W'(1)) begin
            cnt_s = '0;
            if (wrap_s) begin
              end_s = 1'b1;
            end else begin
              addr_s  = next_addr_s;
              state_s = ST_FETCH;
            end
          end else begin
            cnt_s = cnt_r - DUR_W'(1);
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      ST_DONE: begin
        chord_s = '0;
        if (!bus.play) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    if (end_s) begin
      song_done_s = 1'b1;
      chord_s     = '0;
      pend_s      = '0;
      idx_s       = '0;
`ifdef SONG_READER_LOOP_EN
      addr_s      = base_r;
      state_s     = ST_FETCH;
`else
      state_s     = ST_DONE;
`endif
    end else begin
      song_done_s = 1'b0;
    end

    if (bus.play) begin
      notes_s = chord_s;
    end else begin
      notes_s = '0;
    end
    playing_s = (state_s == ST_WAIT) && bus.play;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_r      <= '0;
      base_r      <= '0;
      pend_r      <= '0;
      idx_r       <= '0;
      cnt_r       <= '0;
      chord_r     <= '0;
      notes_r     <= '0;
      new_chord_r <= 1'b0;
      song_done_r <= 1'b0;
      playing_r   <= 1'b0;
    end else begin
      addr_r      <= addr_s;
      base_r      <= base_s;
      pend_r      <= pend_s;
      idx_r       <= idx_s;
      cnt_r       <= cnt_s;
      chord_r     <= chord_s;
      notes_r     <= notes_s;
      new_chord_r <= new_chord_s;
      song_done_r <= song_done_s;
      playing_r   <= playing_s;
    end
  end

  assign bus.addr      = addr_r;
  assign bus.notes     = notes_r;
  assign bus.new_chord = new_chord_r;
  assign bus.song_done = song_done_r;
  assign bus.playing   = playing_r;
endmodule

// File: tb/tb_song_reader.sv
// Scoreboard bench for song_reader: directed songs in a registered ROM model, pulses checked by a monitor.
module tb_song_reader;
  localparam int ADDR_W = 6;
  localparam int SONG_W = 2;
  localparam int NOTE_W = 6;
  localparam int VOICES = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  song_reader_if #(.ADDR_W(ADDR_W), .SONG_W(SONG_W), .NOTE_W(NOTE_W), .VOICES(VOICES)) bus ();

  song_reader #(.ADDR_W(ADDR_W), .SONG_W(SONG_W), .NOTE_W(NOTE_W), .DUR_W(6), .VOICES(VOICES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [15:0] rom [0:63];
  always @(posedge clk) bus.dout <= rom[bus.addr];

  typedef struct {
    bit          is_done;
    logic [17:0] notes;
  } ev_t;

  ev_t exp_q[$];
  ev_t ev;
  int  checks = 0;
  int  errors = 0;

  function automatic logic [15:0] ld(input int n);
    return {1'b0, n[5:0], 9'd0};
  endfunction

  function automatic logic [15:0] pw(input int d);
    return {1'b1, d[5:0], 9'd0};
  endfunction

  function automatic logic [17:0] chord(input int s0, input int s1, input int s2);
    return {s2[5:0], s1[5:0], s0[5:0]};
  endfunction

  task automatic push(input bit is_done, input logic [17:0] n);
    ev_t e;
    e.is_done = is_done;
    e.notes   = n;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // One idle cycle, then a beat seen by exactly one rising edge; returns just after that edge.
  task automatic beat1();
    step();
    bus.beat = 1'b1;
    step();
    bus.beat = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  // which=0 waits for playing, which=1 for song_done; bounded.
  task automatic wait_for(input int which, input string name);
    int n;
    n = 0;
    while (((which == 0) ? bus.playing : bus.song_done) !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL %s: got no event after %0d cycles, expected event", name, n);
    end
  endtask

  // Monitor: every new_chord / song_done pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (bus.new_chord === 1'b1 || bus.song_done === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: got unexpected new_chord=%0b song_done=%0b notes=%0h, expected no event",
                 bus.new_chord, bus.song_done, bus.notes);
      end else begin
        ev = exp_q.pop_front();
        if (ev.is_done) begin
          if (bus.song_done !== 1'b1 || bus.new_chord !== 1'b0) begin
            errors++;
            $display("FAIL scoreboard_done: got new_chord=%0b song_done=%0b, expected song_done only",
                     bus.new_chord, bus.song_done);
          end
        end else if (bus.new_chord !== 1'b1 || bus.song_done !== 1'b0 || bus.notes !== ev.notes) begin
          errors++;
          $display("FAIL scoreboard_chord: got new_chord=%0b song_done=%0b notes=%0h, expected chord notes=%0h",
                   bus.new_chord, bus.song_done, bus.notes, ev.notes);
        end
      end
    end
  end

  initial begin
    for (int a = 0; a < 64; a++) rom[a] = pw(0);
    // song 0: chord of three, hold 12 beats, end
    rom[0] = ld(63); rom[1] = ld(56); rom[2] = ld(59); rom[3] = pw(12); rom[4] = pw(0);
    // song 1: no end marker; extra loads in the second chord are dropped
    rom[16] = ld(5); rom[17] = pw(1);
    for (int a = 18; a <= 30; a++) rom[a] = ld(a - 10);
    rom[31] = pw(1);
    // song 2: overflow
    rom[32] = ld(10); rom[33] = ld(20); rom[34] = ld(30); rom[35] = ld(40); rom[36] = pw(2); rom[37] = pw(0);
    // song 3: partial chord then end
    rom[48] = ld(7); rom[49] = pw(1); rom[50] = pw(0);

    bus.play = 1'b0;
    bus.beat = 1'b0;
    bus.song_sel = '0;
    step();
    step();
    check("reset_addr", bus.addr, 0);
    check("reset_notes", bus.notes, 0);
    check("reset_new_chord", bus.new_chord, 0);
    check("reset_playing", bus.playing, 0);
    check("reset_song_done", bus.song_done, 0);
    reset = 1'b0;
    step();

    // 1: chord and exact beat count
    push(1'b0, chord(63, 56, 59));
    push(1'b1, '0);
    bus.song_sel = 2'd0;
    bus.play = 1'b1;
    wait_for(0, "t1_chord");
    check("t1_notes", bus.notes, chord(63, 56, 59));
    for (int i = 1; i <= 12; i++) begin
      beat1();
      check($sformatf("t1_addr_beat%0d", i), bus.addr, (i < 12) ? 3 : 4);
    end
    wait_for(1, "t1_done");
    bus.play = 1'b0;
    step();
    step();
    check("t1_notes_end", bus.notes, 0);

    // 2: overflow drops the fourth load
    do_reset();
    push(1'b0, chord(10, 20, 30));
    push(1'b1, '0);
    bus.song_sel = 2'd2;
    bus.play = 1'b1;
    wait_for(0, "t2_chord");
    check("t2_notes", bus.notes, chord(10, 20, 30));
    beat1();
    check("t2_addr_hold", bus.addr, 36);
    check("t2_notes_hold", bus.notes, chord(10, 20, 30));
    beat1();
    wait_for(1, "t2_done");
`ifdef SONG_READER_LOOP_EN
    check("t2_addr_end", bus.addr, 32);
`else
    check("t2_addr_end", bus.addr, 37);
`endif
    bus.play = 1'b0;

    // 3: partial chord, one beat, end
    do_reset();
    push(1'b0, chord(7, 0, 0));
    push(1'b1, '0);
    bus.song_sel = 2'd3;
    bus.play = 1'b1;
    wait_for(0, "t3_chord");
    check("t3_notes", bus.notes, chord(7, 0, 0));
    beat1();
    wait_for(1, "t3_done");
    push(1'b0, chord(7, 0, 0));
`ifdef SONG_READER_LOOP_EN
    check("t3_addr_end", bus.addr, 48);
`else
    check("t3_addr_end", bus.addr, 50);
    step(); step(); step();
    check("t3_done_notes", bus.notes, 0);
    check("t3_done_playing", bus.playing, 0);
    bus.play = 1'b0;
    step(); step();
    bus.play = 1'b1;
`endif
    wait_for(0, "t3_restart");
    check("t3_restart_notes", bus.notes, chord(7, 0, 0));
    bus.play = 1'b0;

    // 4: wrap on region 1; song_sel changes mid-song are ignored
    do_reset();
    push(1'b0, chord(5, 0, 0));
    bus.song_sel = 2'd1;
    bus.play = 1'b1;
    step();
    bus.song_sel = 2'd3;
    wait_for(0, "t4_chord1");
    check("t4_notes1", bus.notes, chord(5, 0, 0));
    push(1'b0, chord(8, 9, 10));
    push(1'b1, '0);
    beat1();
    wait_for(0, "t4_chord2");
    check("t4_notes2", bus.notes, chord(8, 9, 10));
    check("t4_addr_last", bus.addr, 31);
    beat1();
    wait_for(1, "t4_done");
`ifdef SONG_READER_LOOP_EN
    check("t4_addr_wrap", bus.addr, 16);
`else
    check("t4_addr_wrap", bus.addr, 31);
`endif
    bus.play = 1'b0;
    step();
`ifdef SONG_READER_LOOP_EN
    check("t4_addr_after", bus.addr, 16);
`else
    check("t4_addr_after", bus.addr, 31);
`endif

    // 5: pause mid-WAIT with 5 beats left
    do_reset();
    push(1'b0, chord(63, 56, 59));
    bus.song_sel = 2'd0;
    bus.play = 1'b1;
    wait_for(0, "t5_chord");
    for (int i = 0; i < 7; i++) beat1();
    bus.play = 1'b0;
    step();
    step();
    check("t5_pause_notes", bus.notes, 0);
    check("t5_pause_playing", bus.playing, 0);
    for (int i = 0; i < 3; i++) beat1();
    check("t5_pause_addr", bus.addr, 3);
    bus.play = 1'b1;
    step();
    step();
    check("t5_resume_notes", bus.notes, chord(63, 56, 59));
    check("t5_resume_playing", bus.playing, 1);
    for (int i = 0; i < 4; i++) beat1();
    check("t5_addr_4beats", bus.addr, 3);
    push(1'b1, '0);
    beat1();
    check("t5_addr_5beats", bus.addr, 4);
    wait_for(1, "t5_done");
    bus.play = 1'b0;

    // 6: async reset mid-WAIT, restart at base
    do_reset();
    push(1'b0, chord(10, 20, 30));
    bus.song_sel = 2'd2;
    bus.play = 1'b1;
    wait_for(0, "t6_chord");
    beat1();
    reset = 1'b1;
    bus.play = 1'b0;
    #1;
    check("t6_rst_addr", bus.addr, 0);
    check("t6_rst_notes", bus.notes, 0);
    check("t6_rst_playing", bus.playing, 0);
    check("t6_rst_new_chord", bus.new_chord, 0);
    check("t6_rst_song_done", bus.song_done, 0);
    step();
    reset = 1'b0;
    step();
    push(1'b0, chord(10, 20, 30));
    bus.play = 1'b1;
    step();
    check("t6_first_fetch", bus.addr, 32);
    wait_for(0, "t6_chord2");
    check("t6_notes2", bus.notes, chord(10, 20, 30));
    bus.play = 1'b0;
    step();
    step();

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
